fetch_sequencer: RTL

Moore-style control FSM that sequences the instruction-fetch datapath around the program counter. It drives the one-hot write-decoder and read-decoder select buses, the PC increment strobe `pcd`, and the memory read handshake. It also hands each fetched instruction to the execute stage and applies taken jumps by loading the PC from the A bus. It sits between the top-level processor control and the register/bus fabric, and is the only block allowed to assert `pcd` or the PC write select.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake and select bus between the fetch sequencer and the processor fabric.
interface fetch_sequencer_if;
    localparam int unsigned WR_W = 20;
    localparam int unsigned RD_W = 19;
    localparam int unsigned FC_W = 16;

    logic            run;
    logic            halt;
    logic            mem_ready;
    logic            exec_done;
    logic            jump_taken;
    logic [WR_W-1:0] WRDec_out;
    logic [RD_W-1:0] RDec_out;
    logic            pcd;
    logic            mem_rd;
    logic            ir_valid;
    logic            busy;
    logic            err;
    logic [FC_W-1:0] fetch_count;

    // Sequencer side
    modport master (
        input  run, halt, mem_ready, exec_done, jump_taken,
        output WRDec_out, RDec_out, pcd, mem_rd, ir_valid, busy, err, fetch_count
    );

    // Fabric / control side
    modport slave (
        output run, halt, mem_ready, exec_done, jump_taken,
        input  WRDec_out, RDec_out, pcd, mem_rd, ir_valid, busy, err, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: sequences PC -> AR, memory read, DR -> IR with
// PC increment, dispatch to execute, and jump-target loads into the PC.
module fetch_sequencer #(
    parameter int unsigned WR_AR_BIT = 0,
    parameter int unsigned WR_IR_BIT = 1,
    parameter int unsigned WR_PC_BIT = 3,
    parameter int unsigned RD_PC_BIT = 0,
    parameter int unsigned RD_DR_BIT = 1,
    parameter int unsigned RD_JT_BIT = 5,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned WR_W   = 20;
    localparam int unsigned RD_W   = 19;
    localparam int unsigned FC_W   = 16;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_MEM,
        S_LOAD,
        S_DISPATCH,
        S_JUMP,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [FC_W-1:0]   fetch_count_q, fetch_count_d;
    logic [WR_W-1:0]   wr_q, wr_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              pcd_q, pcd_d;
    logic              mem_rd_q, mem_rd_d;
    logic              ir_valid_q, ir_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              stop_req;
    logic              wait_expired;

    assign stop_req     = bus.halt || !bus.run;
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

    // Next-state logic; halt/run only matter in IDLE and at instruction boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run && !bus.halt) state_d = S_ADDR;
            end
            S_ADDR: begin
                state_d = S_MEM;
            end
            S_MEM: begin
                if (bus.mem_ready)  state_d = S_LOAD;
                else if (wait_expired) state_d = S_ERR;
            end
            S_LOAD: begin
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (bus.exec_done) begin
                    if (bus.jump_taken) state_d = S_JUMP;
                    else if (stop_req)  state_d = S_IDLE;
                    else                state_d = S_ADDR;
                end
            end
            S_JUMP: begin
                state_d = stop_req ? S_IDLE : S_ADDR;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode of the upcoming state so the registered outputs track state_q
    always_comb begin
        wr_d       = '0;
        rd_d       = '0;
        pcd_d      = 1'b0;
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        case (state_d)
            S_ADDR: begin
                rd_d[RD_PC_BIT] = 1'b1;
                wr_d[WR_AR_BIT] = 1'b1;
                busy_d          = 1'b1;
            end
            S_MEM: begin
                mem_rd_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_LOAD: begin
                rd_d[RD_DR_BIT] = 1'b1;
                wr_d[WR_IR_BIT] = 1'b1;
                pcd_d           = 1'b1;
                busy_d          = 1'b1;
            end
            S_DISPATCH: begin
                ir_valid_d = (state_q != S_DISPATCH);
                busy_d     = 1'b1;
            end
            S_JUMP: begin
                rd_d[RD_JT_BIT] = 1'b1;
                wr_d[WR_PC_BIT] = 1'b1;
                busy_d          = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Wait counter runs only while in MEM, so it is zero on every MEM entry
    always_comb begin
        wait_d        = (state_q == S_MEM) ? WAIT_W'(wait_q + 1'b1) : '0;
        fetch_count_d = (state_q == S_LOAD) ? FC_W'(fetch_count_q + 1'b1) : fetch_count_q;
    end

    // State, counters and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            fetch_count_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            pcd_q         <= 1'b0;
            mem_rd_q      <= 1'b0;
            ir_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            fetch_count_q <= fetch_count_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            pcd_q         <= pcd_d;
            mem_rd_q      <= mem_rd_d;
            ir_valid_q    <= ir_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bus.WRDec_out   = wr_q;
    assign bus.RDec_out    = rd_q;
    assign bus.pcd         = pcd_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
